// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - button inputs and control outputs of the stopwatch controller
interface stopwatch_ctrl_if;
    logic btn_start_stop;
    logic btn_clear;
    logic running;
    logic sec_enable;
    logic counter_clear;

    modport master (
        output btn_start_stop,
        output btn_clear,
        input  running,
        input  sec_enable,
        input  counter_clear
    );

    modport slave (
        input  btn_start_stop,
        input  btn_clear,
        output running,
        output sec_enable,
        output counter_clear
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - button conditioning, IDLE/RUN/PAUSE control and one-second prescaler
module stopwatch_ctrl #(
    parameter int TICKS_PER_SEC   = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic              clk,
    input  logic              rst,
    stopwatch_ctrl_if.slave   sw
);
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [DW-1:0] DCNT_MAX  = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Bit 0 carries start_stop, bit 1 carries clear.
    logic [1:0]         sync1_q, sync1_d;
    logic [1:0]         sync2_q, sync2_d;
    logic [1:0]         db_q, db_d;
    logic [1:0]         db_prev_q, db_prev_d;
    logic [1:0]         press_q, press_d;
    logic [1:0][DW-1:0] dcnt_q, dcnt_d;
    state_t             state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic               clear_q, clear_d;

    always_comb begin
        sync1_d   = {sw.btn_clear, sw.btn_start_stop};
        sync2_d   = sync1_q;
        db_d      = db_q;
        dcnt_d    = dcnt_q;
        db_prev_d = db_q;
        press_d   = db_q & ~db_prev_q;

        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != db_q[b]) begin
                if (dcnt_q[b] == DCNT_MAX) begin
                    db_d[b]   = sync2_q[b];
                    dcnt_d[b] = '0;
                end else begin
                    dcnt_d[b] = dcnt_q[b] + DW'(1);
                end
            end else begin
                dcnt_d[b] = '0;
            end
        end

        // Clear only matters in PAUSE; start_stop wins everywhere else.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (press_q[0]) state_d = ST_RUN;
            ST_RUN:   if (press_q[0]) state_d = ST_PAUSE;
            ST_PAUSE: begin
                if (press_q[1])      state_d = ST_IDLE;
                else if (press_q[0]) state_d = ST_RUN;
            end
            default:  state_d = ST_IDLE;
        endcase

        clear_d = (state_q == ST_PAUSE) && (state_d == ST_IDLE);

        presc_d = presc_q;
        if (state_q == ST_RUN) begin
            presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
        end
        if (clear_d) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            press_q   <= '0;
            dcnt_q    <= '0;
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            clear_q   <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            press_q   <= press_d;
            dcnt_q    <= dcnt_d;
            state_q   <= state_d;
            presc_q   <= presc_d;
            clear_q   <= clear_d;
        end
    end

    assign sw.running       = (state_q == ST_RUN);
    assign sw.sec_enable    = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
    assign sw.counter_clear = clear_q;
endmodule
